// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) constant multipliers for the MixColumns datapath.
package aes_pkg;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [31:0]  aes_col_t;
  typedef logic [127:0] aes_state_t;

  localparam int AES_NCOLS = 4;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by one of the MixColumns / InvMixColumns matrix constants.
  // Only 01/02/03/09/0b/0d/0e are meaningful; anything else yields zero.
  function automatic aes_byte_t gmul_const(input aes_byte_t b, input aes_byte_t c);
    aes_byte_t x2;
    aes_byte_t x4;
    aes_byte_t x8;
    aes_byte_t r;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      8'h01:   r = b;
      8'h02:   r = x2;
      8'h03:   r = x2 ^ b;
      8'h09:   r = x8 ^ b;
      8'h0b:   r = x8 ^ x2 ^ b;
      8'h0d:   r = x8 ^ x4 ^ b;
      8'h0e:   r = x8 ^ x4 ^ x2;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mixcol_column.sv
// Combinational MixColumns transform of one 32-bit column (byte 0 in the MSB).
// With MIXCOL_INV_EN defined the inverse matrix is also built and selected by inv;
// otherwise inv is ignored and only the forward matrix exists.
module mixcol_column
  import aes_pkg::*;
(
  input  logic [31:0] col,
  input  logic        inv,
  output logic [31:0] result
);

  aes_byte_t a0_s, a1_s, a2_s, a3_s;
  aes_col_t  fwd_s;

  assign a0_s = col[31:24];
  assign a1_s = col[23:16];
  assign a2_s = col[15:8];
  assign a3_s = col[7:0];

  // Forward matrix rows {02,03,01,01} and rotations.
  always_comb begin
    fwd_s[31:24] = gmul_const(a0_s, 8'h02) ^ gmul_const(a1_s, 8'h03) ^ a2_s ^ a3_s;
    fwd_s[23:16] = a0_s ^ gmul_const(a1_s, 8'h02) ^ gmul_const(a2_s, 8'h03) ^ a3_s;
    fwd_s[15:8]  = a0_s ^ a1_s ^ gmul_const(a2_s, 8'h02) ^ gmul_const(a3_s, 8'h03);
    fwd_s[7:0]   = gmul_const(a0_s, 8'h03) ^ a1_s ^ a2_s ^ gmul_const(a3_s, 8'h02);
  end

`ifdef MIXCOL_INV_EN
  aes_col_t inv_col_s;

  // Inverse matrix rows {0e,0b,0d,09} and rotations.
  always_comb begin
    inv_col_s[31:24] = gmul_const(a0_s, 8'h0e) ^ gmul_const(a1_s, 8'h0b) ^
                       gmul_const(a2_s, 8'h0d) ^ gmul_const(a3_s, 8'h09);
    inv_col_s[23:16] = gmul_const(a0_s, 8'h09) ^ gmul_const(a1_s, 8'h0e) ^
                       gmul_const(a2_s, 8'h0b) ^ gmul_const(a3_s, 8'h0d);
    inv_col_s[15:8]  = gmul_const(a0_s, 8'h0d) ^ gmul_const(a1_s, 8'h09) ^
                       gmul_const(a2_s, 8'h0e) ^ gmul_const(a3_s, 8'h0b);
    inv_col_s[7:0]   = gmul_const(a0_s, 8'h0b) ^ gmul_const(a1_s, 8'h0d) ^
                       gmul_const(a2_s, 8'h09) ^ gmul_const(a3_s, 8'h0e);
  end

  assign result = inv ? inv_col_s : fwd_s;
`else
  logic inv_unused_s;

  assign inv_unused_s = inv;
  assign result       = fwd_s;
`endif

endmodule

// File: rtl/mixcol_engine.sv
// Iterative AES MixColumns / InvMixColumns engine.
// Accepts a 128-bit state in IDLE, transforms COLS_PER_CYCLE columns per cycle in
// BUSY, then presents the result in DONE until the downstream accepts it.
// Optional feature macro: MIXCOL_INV_EN (per-block inverse direction via in_inv).
module mixcol_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NCOLS = AES_NCOLS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  logic [1:0] state_r, state_nxt_s;
  logic [1:0] col_cnt_r, col_cnt_nxt_s;
  aes_state_t st_r, st_nxt_s;
  logic       inv_r, inv_nxt_s;
  logic       in_ready_r, out_valid_r, busy_r;
  logic       in_inv_s;
  logic       last_s;

  aes_col_t   cols_s       [NCOLS];
  aes_col_t   mixed_cols_s [NCOLS];
  aes_state_t st_mixed_s;
  aes_col_t   mix_in_s     [COLS_PER_CYCLE];
  aes_col_t   mix_out_s    [COLS_PER_CYCLE];
  logic [1:0] mix_idx_s    [COLS_PER_CYCLE];

`ifdef MIXCOL_INV_EN
  assign in_inv_s = in_inv;
`else
  logic in_inv_unused_s;

  assign in_inv_unused_s = in_inv;
  assign in_inv_s        = 1'b0;
`endif

  // The block finishes on the step that covers column 3.
  assign last_s = (({1'b0, col_cnt_r} + 3'(COLS_PER_CYCLE)) == 3'd4);

  // Split the held state into its four columns.
  always_comb begin
    for (int c = 0; c < NCOLS; c++) begin
      cols_s[c] = st_r[127 - 32*c -: 32];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign mix_idx_s[g] = col_cnt_r + 2'(g);
    assign mix_in_s[g]  = cols_s[mix_idx_s[g]];

    mixcol_column u_col (
      .col    (mix_in_s[g]),
      .inv    (inv_r),
      .result (mix_out_s[g])
    );
  end

  // Merge the freshly transformed columns back into the state.
  always_comb begin
    for (int c = 0; c < NCOLS; c++) begin
      mixed_cols_s[c] = cols_s[c];
    end
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      mixed_cols_s[mix_idx_s[g]] = mix_out_s[g];
    end
    st_mixed_s = 128'd0;
    for (int c = 0; c < NCOLS; c++) begin
      st_mixed_s[127 - 32*c -: 32] = mixed_cols_s[c];
    end
  end

  // Next-state logic: accept in IDLE, step columns in BUSY, hold in DONE until taken.
  always_comb begin
    state_nxt_s   = state_r;
    col_cnt_nxt_s = col_cnt_r;
    st_nxt_s      = st_r;
    inv_nxt_s     = inv_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt_s   = ST_BUSY;
          st_nxt_s      = in_data;
          inv_nxt_s     = in_inv_s;
          col_cnt_nxt_s = 2'd0;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_BUSY: begin
        st_nxt_s = st_mixed_s;
        if (last_s) begin
          state_nxt_s   = ST_DONE;
        end else begin
          col_cnt_nxt_s = col_cnt_r + STEP;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      col_cnt_r   <= 2'd0;
      st_r        <= 128'd0;
      inv_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      col_cnt_r   <= col_cnt_nxt_s;
      st_r        <= st_nxt_s;
      inv_r       <= inv_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_data  = st_r;

endmodule

// File: tb/tb_mixcol_engine.sv
// Directed self-checking bench for mixcol_engine at COLS_PER_CYCLE = 1, 2 and 4.
// The inverse-direction checks depend on MIXCOL_INV_EN.
module tb_mixcol_engine;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_inv;
  logic [127:0] in_data;
  logic         out_ready;

  logic         ir1, ir2, ir4;
  logic         ov1, ov2, ov4;
  logic         bz1, bz2, bz4;
  logic [127:0] od1, od2, od4;

  int checks_cnt = 0;
  int errors_cnt = 0;

  localparam logic [127:0] FIPS_IN  = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [127:0] FIPS_OUT = 128'h5f72641557f5bc92f7be3b291db9f91a;
  localparam logic [127:0] COL_IN   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] COL_OUT  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  mixcol_engine #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_inv(in_inv),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .busy(bz1)
  );
  mixcol_engine #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .in_inv(in_inv),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .busy(bz2)
  );
  mixcol_engine #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .in_inv(in_inv),
    .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .busy(bz4)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one block to all three engines (all idle), then record each engine's
  // first out_valid sample (counted in cycles after the acceptance edge) and data.
  task automatic xfer(input logic [127:0] d, input logic inv,
                      output logic [127:0] r1, output logic [127:0] r2, output logic [127:0] r4,
                      output int l1, output int l2, output int l4);
    r1 = 128'd0; r2 = 128'd0; r4 = 128'd0;
    l1 = 0; l2 = 0; l4 = 0;
    @(negedge clk);
    in_data  = d;
    in_inv   = inv;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (ov1 && l1 == 0) begin l1 = n; r1 = od1; end
      if (ov2 && l2 == 0) begin l2 = n; r2 = od2; end
      if (ov4 && l4 == 0) begin l4 = n; r4 = od4; end
      if (l1 != 0 && l2 != 0 && l4 != 0) break;
    end
  endtask

  initial begin
    logic [127:0] r1, r2, r4, ra, rb, rc;
    int           l1, l2, l4, la, lb, lc;
    logic         seen;
    logic         stale;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_inv    = 1'b0;
    in_data   = 128'd0;
    out_ready = 1'b1;

    // Reset state
    #12;
    check_val("rst_in_ready",  128'(ir1), 128'(1'b1));
    check_val("rst_out_valid", 128'(ov1), 128'(1'b0));
    check_val("rst_busy",      128'(bz1), 128'(1'b0));
    check_val("rst_out_data",  od1, 128'd0);
    check_val("rst_ready_cpc4", 128'(ir4), 128'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 round-1 forward vector at all three throughputs
    xfer(FIPS_IN, 1'b0, r1, r2, r4, l1, l2, l4);
    check_val("fips_fwd_cpc1", r1, FIPS_OUT);
    check_val("fips_fwd_cpc2", r2, FIPS_OUT);
    check_val("fips_fwd_cpc4", r4, FIPS_OUT);
    check_val("lat_cpc1", 128'(l1), 128'd5);
    check_val("lat_cpc2", 128'(l2), 128'd3);
    check_val("lat_cpc4", 128'(l4), 128'd2);

    // Per-column vectors
    xfer(COL_IN, 1'b0, r1, r2, r4, l1, l2, l4);
    check_val("col_fwd_cpc1", r1, COL_OUT);
    check_val("col_fwd_cpc2", r2, COL_OUT);
    check_val("col_fwd_cpc4", r4, COL_OUT);

`ifdef MIXCOL_INV_EN
    // Inverse direction and round trip
    xfer(FIPS_OUT, 1'b1, r1, r2, r4, l1, l2, l4);
    check_val("fips_inv_cpc1", r1, FIPS_IN);
    check_val("fips_inv_cpc2", r2, FIPS_IN);
    check_val("fips_inv_cpc4", r4, FIPS_IN);
    xfer(COL_OUT, 1'b1, r1, r2, r4, l1, l2, l4);
    check_val("col_inv_cpc1", r1, COL_IN);
    xfer(128'h0123456789abcdef_fedcba9876543210, 1'b0, ra, rb, rc, la, lb, lc);
    xfer(ra, 1'b1, r1, r2, r4, l1, l2, l4);
    check_val("roundtrip_cpc1", r1, 128'h0123456789abcdef_fedcba9876543210);
    xfer(rc, 1'b1, r1, r2, r4, l1, l2, l4);
    check_val("roundtrip_cpc4", r4, 128'h0123456789abcdef_fedcba9876543210);
`else
    // Direction bit is ignored when the inverse is not built
    xfer(COL_IN, 1'b1, r1, r2, r4, l1, l2, l4);
    check_val("inv_ignored_cpc1", r1, COL_OUT);
    check_val("inv_ignored_cpc4", r4, COL_OUT);
`endif

    // Backpressure: hold DONE for 10 cycles with a second block pending
    out_ready = 1'b0;
    @(negedge clk);
    in_data  = COL_IN;
    in_inv   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_data = FIPS_IN;
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (ov1) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("bp_reached_done", 128'(seen), 128'(1'b1));
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check_val("bp_data_stable", od1, COL_OUT);
      check_val("bp_in_ready_low", 128'(ir1), 128'(1'b0));
      check_val("bp_valid_held", 128'(ov1), 128'(1'b1));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("bp_back_idle", 128'(ir1), 128'(1'b1));
    check_val("bp_valid_dropped", 128'(ov1), 128'(1'b0));
    @(posedge clk);
    #1 in_valid = 1'b0;
    l1 = 0;
    r1 = 128'd0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (ov1) begin
        l1 = n;
        r1 = od1;
        break;
      end
    end
    check_val("bp_second_block", r1, FIPS_OUT);
    check_val("bp_second_lat", 128'(l1), 128'd5);

    // Asynchronous reset in the middle of BUSY
    repeat (2) @(negedge clk);
    in_data  = FIPS_IN;
    in_inv   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_val("mid_busy_high", 128'(bz1), 128'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_out_valid", 128'(ov1), 128'(1'b0));
    check_val("arst_in_ready",  128'(ir1), 128'(1'b1));
    check_val("arst_busy",      128'(bz1), 128'(1'b0));
    check_val("arst_out_data",  od1, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ov1 || ov2 || ov4 || bz1) stale = 1'b1;
    end
    check_val("no_stale_result", 128'(stale), 128'(1'b0));

    // Engine is usable again after reset
    xfer(FIPS_IN, 1'b0, r1, r2, r4, l1, l2, l4);
    check_val("post_rst_cpc1", r1, FIPS_OUT);
    check_val("post_rst_cpc2", r2, FIPS_OUT);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
